// File: rtl/ibex_bus_arbiter2.sv
// Two-master, one-slave req/gnt/rvalid arbiter with a single outstanding transaction.
// The command is passed through in IDLE and held in registers while the slave stalls.
module ibex_bus_arbiter2 #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned AddrWidth  = 32,
    parameter bit          RoundRobin = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   m0_req_i,
    input  logic [AddrWidth-1:0]   m0_addr_i,
    input  logic                   m0_we_i,
    input  logic [DataWidth/8-1:0] m0_be_i,
    input  logic [DataWidth-1:0]   m0_wdata_i,
    output logic                   m0_gnt_o,
    output logic                   m0_rvalid_o,
    output logic                   m0_err_o,
    output logic [DataWidth-1:0]   m0_rdata_o,
    input  logic                   m1_req_i,
    input  logic [AddrWidth-1:0]   m1_addr_i,
    input  logic                   m1_we_i,
    input  logic [DataWidth/8-1:0] m1_be_i,
    input  logic [DataWidth-1:0]   m1_wdata_i,
    output logic                   m1_gnt_o,
    output logic                   m1_rvalid_o,
    output logic                   m1_err_o,
    output logic [DataWidth-1:0]   m1_rdata_o,
    output logic                   s_req_o,
    output logic [AddrWidth-1:0]   s_addr_o,
    output logic                   s_we_o,
    output logic [DataWidth/8-1:0] s_be_o,
    output logic [DataWidth-1:0]   s_wdata_o,
    input  logic                   s_gnt_i,
    input  logic                   s_rvalid_i,
    input  logic                   s_err_i,
    input  logic [DataWidth-1:0]   s_rdata_i,
    output logic                   busy_o,
    output logic                   owner_o
);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_e;

    state_e                 state_q, state_d;
    logic                   owner_q, last_owner_q;
    logic [AddrWidth-1:0]   addr_q;
    logic                   we_q;
    logic [DataWidth/8-1:0] be_q;
    logic [DataWidth-1:0]   wdata_q;

    logic                   any_req, winner;
    logic [AddrWidth-1:0]   win_addr;
    logic                   win_we;
    logic [DataWidth/8-1:0] win_be;
    logic [DataWidth-1:0]   win_wdata;
    logic [1:0]             gnt, rvalid, err;

    assign any_req = m0_req_i | m1_req_i;

    // On a tie, round-robin favours whoever did not win the last slave grant.
    always_comb begin
        if (m0_req_i && m1_req_i) winner = RoundRobin ? ~last_owner_q : 1'b0;
        else                      winner = m1_req_i & ~m0_req_i;
    end

    assign win_addr  = winner ? m1_addr_i  : m0_addr_i;
    assign win_we    = winner ? m1_we_i    : m0_we_i;
    assign win_be    = winner ? m1_be_i    : m0_be_i;
    assign win_wdata = winner ? m1_wdata_i : m0_wdata_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (any_req) state_d = s_gnt_i ? WAIT_RSP : WAIT_GNT;
            WAIT_GNT: if (s_gnt_i) state_d = WAIT_RSP;
            WAIT_RSP: if (s_rvalid_i || s_err_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        s_req_o   = 1'b0;
        s_addr_o  = addr_q;
        s_we_o    = we_q;
        s_be_o    = be_q;
        s_wdata_o = wdata_q;
        gnt       = 2'b00;
        rvalid    = 2'b00;
        err       = 2'b00;
        unique case (state_q)
            IDLE: begin
                s_req_o   = any_req;
                s_addr_o  = win_addr;
                s_we_o    = win_we;
                s_be_o    = win_be;
                s_wdata_o = win_wdata;
                gnt[winner] = any_req & s_gnt_i;
            end
            WAIT_GNT: begin
                s_req_o      = 1'b1;
                gnt[owner_q] = s_gnt_i;
            end
            WAIT_RSP: begin
                rvalid[owner_q] = s_rvalid_i;
                err[owner_q]    = s_err_i;
            end
            default: ;
        endcase
    end

    // Owner and the stalled command are captured at request time; last_owner only moves on a grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
        end else begin
            if (state_q == IDLE && any_req) begin
                owner_q <= winner;
                if (s_gnt_i) begin
                    last_owner_q <= winner;
                end else begin
                    addr_q  <= win_addr;
                    we_q    <= win_we;
                    be_q    <= win_be;
                    wdata_q <= win_wdata;
                end
            end
            if (state_q == WAIT_GNT && s_gnt_i) last_owner_q <= owner_q;
        end
    end

    assign m0_gnt_o    = gnt[0];
    assign m1_gnt_o    = gnt[1];
    assign m0_rvalid_o = rvalid[0];
    assign m1_rvalid_o = rvalid[1];
    assign m0_err_o    = err[0];
    assign m1_err_o    = err[1];
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign busy_o      = (state_q != IDLE);
    assign owner_o     = owner_q;

endmodule
